// File: rtl/pagerank_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pagerank_iter_ctrl
// Description : Iteration sequencer for the pageRank datapath. Latches a graph
//               configuration, holds the datapath in reset, then samples
//               node0Val once per iteration until it converges within eps or
//               the iteration cap is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module pagerank_iter_ctrl #(
    parameter int N        = 16,
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6,
    parameter int RST_CYC  = 2,
    parameter int ITER_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N*N-1:0]       adj_in,
    input  logic [N*WIDTH-1:0]   weight_in,
    input  logic [WIDTH-1:0]     eps,
    output logic                 pr_reset,
    output logic [N*N-1:0]       pr_adj,
    output logic [N*WIDTH-1:0]   pr_nodeWeight,
    input  logic [WIDTH-1:0]     pr_nodeVal,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [ITER_W-1:0]    iter_count,
    output logic [WIDTH-1:0]     result
);

    // One shared cycle counter serves both the LOAD and RUN dwell times.
    localparam int CNT_MAX = (RST_CYC > ITER_CYC) ? RST_CYC : ITER_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [N*N-1:0]       adj_q,    adj_d;
    logic [N*WIDTH-1:0]   wt_q,     wt_d;
    logic [ITER_W-1:0]    iter_q,   iter_d;
    logic                 conv_q,   conv_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     prev_q,   prev_d;

    logic [WIDTH-1:0]     delta;
    logic [ITER_W-1:0]    iter_inc;

    // Absolute difference taken in the larger-minus-smaller direction so it
    // never wraps; the incremented count drives the termination decisions.
    always_comb begin
        delta    = (pr_nodeVal >= prev_q) ? (pr_nodeVal - prev_q) : (prev_q - pr_nodeVal);
        iter_inc = iter_q + ITER_W'(1);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            adj_q    <= '0;
            wt_q     <= '0;
            iter_q   <= '0;
            conv_q   <= 1'b0;
            result_q <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adj_q    <= adj_d;
            wt_q     <= wt_d;
            iter_q   <= iter_d;
            conv_q   <= conv_d;
            result_q <= result_d;
            prev_q   <= prev_d;
        end
    end

    // Next-state and register-update logic for the iteration sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adj_d    = adj_q;
        wt_d     = wt_q;
        iter_d   = iter_q;
        conv_d   = conv_q;
        result_d = result_q;
        prev_d   = prev_q;

        case (state_q)
            S_IDLE: begin
                // abort outranks start so a simultaneous pair stays idle
                if (start && !abort) begin
                    adj_d    = adj_in;
                    wt_d     = weight_in;
                    iter_d   = '0;
                    conv_d   = 1'b0;
                    result_d = '0;
                    prev_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                if (abort) begin
                    conv_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RUN: begin
                if (abort) begin
                    conv_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(ITER_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CHECK: begin
                if (abort) begin
                    // an aborted check leaves result and count untouched
                    conv_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    result_d = pr_nodeVal;
                    prev_d   = pr_nodeVal;
                    iter_d   = iter_inc;
                    cnt_d    = '0;
                    if ((iter_inc >= ITER_W'(2)) && (delta <= eps)) begin
                        conv_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (iter_inc == ITER_W'(MAX_ITER)) begin
                        conv_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the current state.
    assign pr_reset      = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy          = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pr_adj        = adj_q;
    assign pr_nodeWeight = wt_q;
    assign converged     = conv_q;
    assign iter_count    = iter_q;
    assign result        = result_q;

endmodule
`default_nettype wire

// File: tb/tb_pagerank_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pagerank_iter_ctrl
// Description : Directed self-checking bench for pagerank_iter_ctrl with a
//               scoreboard of expected run outcomes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pagerank_iter_ctrl;

    localparam int N        = 4;
    localparam int WIDTH    = 16;
    localparam int MAX_ITER = 8;
    localparam int ITER_W   = 4;
    localparam int RST_CYC  = 2;
    localparam int ITER_CYC = 1;
    localparam int PERIOD   = ITER_CYC + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [N*N-1:0]       adj_in;
    logic [N*WIDTH-1:0]   weight_in;
    logic [WIDTH-1:0]     eps;
    logic                 pr_reset;
    logic [N*N-1:0]       pr_adj;
    logic [N*WIDTH-1:0]   pr_nodeWeight;
    logic [WIDTH-1:0]     pr_nodeVal;
    logic                 busy;
    logic                 done;
    logic                 converged;
    logic [ITER_W-1:0]    iter_count;
    logic [WIDTH-1:0]     result;

    typedef struct {
        logic [WIDTH-1:0]  res;
        logic [ITER_W-1:0] iter;
        logic              conv;
        int                end_cyc;
        bit                aborted;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] seq[$];
    int               vecs = 0;
    int               errs = 0;

    pagerank_iter_ctrl #(
        .N(N), .WIDTH(WIDTH), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W),
        .RST_CYC(RST_CYC), .ITER_CYC(ITER_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .adj_in(adj_in), .weight_in(weight_in), .eps(eps),
        .pr_reset(pr_reset), .pr_adj(pr_adj), .pr_nodeWeight(pr_nodeWeight),
        .pr_nodeVal(pr_nodeVal), .busy(busy), .done(done),
        .converged(converged), .iter_count(iter_count), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pr_reset"},   64'(pr_reset),      64'd1);
        chk({tag, "_busy"},       64'(busy),          64'd0);
        chk({tag, "_done"},       64'(done),          64'd0);
        chk({tag, "_converged"},  64'(converged),     64'd0);
        chk({tag, "_iter"},       64'(iter_count),    64'd0);
        chk({tag, "_result"},     64'(result),        64'd0);
        chk({tag, "_pr_adj"},     64'(pr_adj),        64'd0);
        chk({tag, "_pr_weight"},  64'(pr_nodeWeight), 64'd0);
    endtask

    // Reference model: walk the sample sequence and decide when/how the run ends.
    task automatic push_expect(input logic [WIDTH-1:0] e, input int abort_at);
        exp_t             x;
        logic [WIDTH-1:0] prev = '0;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] d;
        int               kfin = MAX_ITER;
        bit               cv = 1'b0;
        int               kdone = 0;
        for (int k = 1; k <= MAX_ITER; k++) begin
            v = seq[(k - 1) % seq.size()];
            d = (v > prev) ? v - prev : prev - v;
            prev = v;
            if (k >= 2 && d <= e) begin
                kfin = k;
                cv   = 1'b1;
                break;
            end
        end
        if (abort_at > 0) begin
            for (int k = 1; k <= kfin; k++)
                if (RST_CYC + k * PERIOD < abort_at) kdone = k;
            x.res     = (kdone > 0) ? seq[(kdone - 1) % seq.size()] : '0;
            x.iter    = ITER_W'(kdone);
            x.conv    = 1'b0;
            x.end_cyc = abort_at + 1;
            x.aborted = 1'b1;
        end else begin
            x.res     = seq[(kfin - 1) % seq.size()];
            x.iter    = ITER_W'(kfin);
            x.conv    = cv;
            x.end_cyc = RST_CYC + kfin * PERIOD + 1;
            x.aborted = 1'b0;
        end
        sb.push_back(x);
    endtask

    // Start a run, feed samples at each CHECK cycle, and score the outcome.
    task automatic run_case(input string tag, input logic [WIDTH-1:0] e,
                            input int abort_at, input int start_busy_at);
        logic [N*N-1:0]     exp_adj;
        logic [N*WIDTH-1:0] exp_wt;
        exp_t               x;
        int                 t;
        bit                 ended;
        bit                 saw_done;
        exp_adj   = N*N'($urandom);
        exp_wt    = {$urandom, $urandom};
        adj_in    = exp_adj;
        weight_in = exp_wt;
        eps       = e;
        push_expect(e, abort_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_latch_adj"}, 64'(pr_adj),        64'(exp_adj));
        chk({tag, "_latch_wt"},  64'(pr_nodeWeight), 64'(exp_wt));
        chk({tag, "_start_iter"}, 64'(iter_count),   64'd0);
        t = 1;
        ended = 1'b0;
        saw_done = 1'b0;
        while (!ended && t < 200) begin
            if (done) begin
                ended = 1'b1;
                saw_done = 1'b1;
            end else if (!busy) begin
                ended = 1'b1;
            end else begin
                chk({tag, "_pr_reset"}, 64'(pr_reset), 64'(t <= RST_CYC));
                adj_in    = N*N'($urandom);
                weight_in = {$urandom, $urandom};
                if (t > RST_CYC && (t - RST_CYC) % PERIOD == 0)
                    pr_nodeVal = seq[((t - RST_CYC) / PERIOD - 1) % seq.size()];
                abort = (t == abort_at);
                start = (t == start_busy_at);
                tick();
                t++;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        x = sb.pop_front();
        chk({tag, "_end_cycle"}, 64'(t),          64'(x.end_cyc));
        chk({tag, "_done_seen"}, 64'(saw_done),   64'(!x.aborted));
        chk({tag, "_busy_end"},  64'(busy),       64'd0);
        chk({tag, "_pr_reset_end"}, 64'(pr_reset), 64'(x.aborted));
        chk({tag, "_result"},    64'(result),     64'(x.res));
        chk({tag, "_iter"},      64'(iter_count), 64'(x.iter));
        chk({tag, "_conv"},      64'(converged),  64'(x.conv));
        chk({tag, "_adj_hold"},  64'(pr_adj),     64'(exp_adj));
        tick();
        chk({tag, "_done_after"}, 64'(done),      64'd0);
        chk({tag, "_conv_held"}, 64'(converged),  64'(x.conv));
        chk({tag, "_iter_held"}, 64'(iter_count), 64'(x.iter));
        chk({tag, "_res_held"},  64'(result),     64'(x.res));
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        adj_in     = '0;
        weight_in  = '0;
        eps        = '0;
        pr_nodeVal = '0;
        tick();
        tick();
        reset = 1'b1;
        chk_reset_state("por");
        tick();

        // convergence after four samples
        seq = '{16'd100, 16'd200, 16'd205, 16'd206};
        run_case("conv4", 16'd2, 0, 0);

        // full-swing alternation never converges: cap reached
        seq = '{16'h0000, 16'hFFFF};
        run_case("cap", 16'd2, 0, 0);

        // eps=0 exact equality, with a stray start while busy
        seq = '{16'h5555};
        run_case("eps0", 16'd0, 0, 5);

        // abort during RUN of iteration 3
        seq = '{16'h0000, 16'hFFFF};
        run_case("abort", 16'd2, 7, 0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy",     64'(busy),       64'd0);
        chk("sa_pr_reset", 64'(pr_reset),   64'd1);
        chk("sa_iter",     64'(iter_count), 64'd2);
        tick();
        chk("sa_busy2",    64'(busy),       64'd0);

        // reset asserted mid-RUN
        seq = '{16'h1234};
        adj_in    = '1;
        weight_in = '1;
        pr_nodeVal = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mr_in_run", 64'(pr_reset), 64'd0);
        reset = 1'b0;
        tick();
        chk_reset_state("midrst");
        reset = 1'b1;
        tick();
        chk("mr_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
